// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] KEY_NONE       = 8'h00;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer plus glitch filter for an asynchronous PS/2 line; emits a pulse on each filtered fall.
module ps2_line_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic raw,
    output logic fall
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   synced_c;
    logic                   settle_c;

    assign synced_c = sync_q[SYNC_STAGES-1];
    // The FILTER_LEN-th consecutive differing sample commits the new level.
    assign settle_c = (synced_c != filt_q) && (cnt_q == CNT_W'(FILTER_LEN - 1));

    // Metastability chain; idles high like the PS/2 bus.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive samples that disagree with the filtered level.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (synced_c == filt_q) begin
            cnt_q  <= '0;
        end else if (settle_c) begin
            filt_q <= synced_c;
            cnt_q  <= '0;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // One-cycle pulse when the filtered level goes from 1 to 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fall <= 1'b0;
        end else begin
            fall <= settle_c && filt_q;
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frames bytes, decodes E0/F0 prefixes and holds the current make code.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       extended,
    output logic       key_event,
    output logic       frame_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_acc_q, par_acc_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   ext_pend_q, ext_pend_d;
    logic                   brk_pend_q, brk_pend_d;
    logic [7:0]             keycode_d;
    logic                   extended_d;
    logic                   key_event_d;
    logic                   frame_err_d;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   dat_s;
    logic                   clk_fall;

    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .raw     (PS2_CLK),
        .fall    (clk_fall)
    );

    // Data line only needs synchronizing; it is sampled well after it settles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dat_sync_q <= '1;
        end else begin
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
        end
    end

    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    // Frame state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath and output decode; advances on clock falls or on timeout.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_acc_d   = par_acc_q;
        to_cnt_d    = to_cnt_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        keycode_d   = keycode;
        extended_d  = extended;
        key_event_d = 1'b0;
        frame_err_d = 1'b0;

        if (clk_fall) begin
            to_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!dat_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        par_acc_d = 1'b0;
                    end
                end
                DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    par_acc_d = par_acc_q ^ dat_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_acc_d = par_acc_q ^ dat_s;
                    state_d   = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (dat_s && par_acc_q) begin
                        if (shift_q == PS2_PREFIX_EXT) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == PS2_PREFIX_BRK) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            if (!brk_pend_q) begin
                                keycode_d   = shift_q;
                                extended_d  = ext_pend_q;
                                key_event_d = 1'b1;
                            end else if ((shift_q == keycode) && (ext_pend_q == extended)) begin
                                keycode_d   = KEY_NONE;
                                extended_d  = 1'b0;
                                key_event_d = 1'b1;
                            end
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                to_cnt_d    = '0;
                frame_err_d = 1'b1;
                ext_pend_d  = 1'b0;
                brk_pend_d  = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Datapath, prefix and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            to_cnt_q   <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            keycode    <= KEY_NONE;
            extended   <= 1'b0;
            key_event  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            to_cnt_q   <= to_cnt_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            keycode    <= keycode_d;
            extended   <= extended_d;
            key_event  <= key_event_d;
            frame_err  <= frame_err_d;
        end
    end

endmodule
